// File: rtl/nibble_deserializer_if.sv
// Bus bundle for nibble_deserializer.
//   Serial side : shift_en, serial_in, dir, sync_clr (into the deserializer)
//   Word side   : data_out, out_valid (out of it), out_ready (into it)
//   Status      : bit_count, fifo_count, overflow (out of it)
// The slave modport is the deserializer's view. The master modport is the
// view of whoever feeds bits and consumes words.
interface nibble_deserializer_if #(
  parameter int W = 4
) ();
  logic          shift_en;
  logic          serial_in;
  logic          dir;
  logic          sync_clr;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    bit_count;
  logic [1:0]    fifo_count;
  logic          overflow;

  modport slave (
    input  shift_en,
    input  serial_in,
    input  dir,
    input  sync_clr,
    input  out_ready,
    output data_out,
    output out_valid,
    output bit_count,
    output fifo_count,
    output overflow
  );

  modport master (
    output shift_en,
    output serial_in,
    output dir,
    output sync_clr,
    output out_ready,
    input  data_out,
    input  out_valid,
    input  bit_count,
    input  fifo_count,
    input  overflow
  );
endinterface

// File: rtl/nibble_deserializer.sv
// nibble_deserializer
// Collects a serial bit stream into W-bit words (W = 4 or 8) and queues the
// completed words in a 2-entry FIFO with a valid/ready output handshake.
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   bus.slave  serial inputs, word output handshake and status:
//     shift_en/serial_in  sample one bit per edge while shift_en=1
//     dir                 1 = MSB-first, 0 = LSB-first (per bit)
//     sync_clr            clears partial word and overflow flag
//     data_out/out_valid/out_ready  FIFO head and pop handshake
//     bit_count           bits collected in the partial word
//     fifo_count          words queued (0..2)
//     overflow            sticky: a completed word was dropped
module nibble_deserializer #(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_deserializer_if.slave  bus
);

  localparam logic [3:0] LAST_BIT = 4'(W - 1);

  logic [W-1:0] shreg_q, shreg_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0] head_q, head_d;   // FIFO entry 0 (oldest)
  logic [W-1:0] tail_q, tail_d;   // FIFO entry 1
  logic [1:0]   fifo_cnt_q, fifo_cnt_d;
  logic         overflow_q, overflow_d;

  logic         accept;
  logic         word_done;
  logic         pop;
  logic [W-1:0] shifted;

  always_comb begin
    accept     = bus.shift_en & ~bus.sync_clr;
    shifted    = bus.dir ? {shreg_q[W-2:0], bus.serial_in}
                         : {bus.serial_in, shreg_q[W-1:1]};
    word_done  = accept && (bit_cnt_q == LAST_BIT);
    pop        = (fifo_cnt_q != 2'd0) && bus.out_ready;

    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_cnt_d = fifo_cnt_q;
    overflow_d = overflow_q;

    if (bus.sync_clr) begin
      shreg_d    = '0;
      bit_cnt_d  = 4'd0;
      overflow_d = 1'b0;
    end else if (accept) begin
      shreg_d   = shifted;
      bit_cnt_d = word_done ? 4'd0 : bit_cnt_q + 4'd1;
    end

    // The completed word is the shifted value, so the bit sampled on the
    // completing edge is already part of what gets written.
    unique case ({word_done, pop})
      2'b11: begin
        // Simultaneous push and pop keeps the count; when full the tail
        // moves up and the new word takes its place, so order is kept.
        if (fifo_cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = shifted;
        end else begin
          head_d = shifted;
        end
      end
      2'b10: begin
        if (fifo_cnt_q == 2'd0) begin
          head_d     = shifted;
          fifo_cnt_d = 2'd1;
        end else if (fifo_cnt_q == 2'd1) begin
          tail_d     = shifted;
          fifo_cnt_d = 2'd2;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q    <= '0;
      bit_cnt_q  <= 4'd0;
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fifo_cnt_q <= fifo_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Stale head contents are masked so an empty FIFO always reads as zero.
  assign bus.data_out   = (fifo_cnt_q != 2'd0) ? head_q : '0;
  assign bus.out_valid  = (fifo_cnt_q != 2'd0);
  assign bus.bit_count  = bit_cnt_q;
  assign bus.fifo_count = fifo_cnt_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/nibble_deserializer.md
NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

Interface
REQ-001 Parameter: W, default 4, data word width in bits; the legal values are 4 and 8.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 shift_en  input  1  when high at a rising edge, serial_in is sampled as one data bit.
REQ-005 serial_in  input  1  serial bit stream, fed by the upstream shift register's serial_out.
REQ-006 dir  input  1  bit order per sampled bit: 1 = MSB-first, 0 = LSB-first.
REQ-007 sync_clr  input  1  synchronous clear of the partial word and the overflow flag.
REQ-008 data_out  output  W  assembled word at the FIFO head.
REQ-009 out_valid  output  1  data_out holds a valid word.
REQ-010 out_ready  input  1  consumer accepts the head word.
REQ-011 bit_count  output  4  number of bits collected in the current partial word.
REQ-012 fifo_count  output  2  number of words held in the output FIFO (0..2).
REQ-013 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 A bit is accepted on every rising edge where shift_en=1 and sync_clr=0.
REQ-015 Bit order per accepted bit:
- dir=1: shreg becomes {shreg[W-2:0], serial_in}.
- dir=0: shreg becomes {serial_in, shreg[W-1:1]}.
REQ-016 Each accepted bit increments bit_count by 1; on the W-th bit, bit_count wraps to 0 and the word is complete.
REQ-017 Completed word write: the word includes the bit accepted on the same edge, and it is written to the FIFO on that edge.
- out_valid/fifo_count reflect the write on the next cycle (1-cycle latency).
REQ-018 The output FIFO has 2 entries with first-in, first-out order; data_out is the head entry; out_valid = (fifo_count != 0).
REQ-019 Pop occurs on a rising edge where out_valid=1 and out_ready=1; data_out advances to the next entry or goes invalid.
REQ-020 out_ready while out_valid=0 has no effect.
REQ-021 Push and pop on the same edge:
- fifo_count is unchanged.
- FIFO order is preserved.
- This is legal when full and does not set overflow.
REQ-022 Word completes while fifo_count=2 with no pop on that edge:
- The word is discarded.
- overflow is set to 1 and holds.
- The FIFO contents are unchanged.
REQ-023 sync_clr=1 at an edge:
- bit_count and shreg are set to 0.
- overflow is set to 0.
- A coincident shift_en bit is discarded.
- The FIFO and pops are unaffected.
REQ-024 A change of dir mid-word applies from the next accepted bit; already collected bits are not reordered.
REQ-025 When out_valid=0, data_out shall drive all zeros.

Reset
REQ-026 rst low asynchronously forces all of the following, independent of clk:
- bit_count=0, shreg=0
- fifo_count=0, out_valid=0, data_out=0
- overflow=0
REQ-027 Reset asserted mid-word or mid-handshake discards all partial and queued data; the first accepted bit after rst rises counts as bit 1.
REQ-028 Deassertion of rst takes effect at the first rising edge with rst high; no bit is accepted while rst is low.

Verification
REQ-029 MSB-first, W=4, dir=1, serial_in 1,1,0,0 over 4 shift_en cycles, out_ready=0 -> next cycle: out_valid=1, data_out=4'b1100, fifo_count=1, bit_count=0.
REQ-030 LSB-first, dir=0, serial_in 1,0,0,0 -> data_out=4'b0001; then out_ready=1 for 1 cycle -> out_valid=0, data_out=0, fifo_count=0.
REQ-031 Overflow, out_ready=0: three words streamed (4'hA, 4'h5, 4'hF) -> fifo_count=2, overflow=1, and pops yield A then 5. A following sync_clr pulse -> overflow=0.
REQ-032 Full FIFO with out_ready=1 held while the third word completes -> no overflow, fifo_count stays 2, and pops yield words in order 1, 2, 3.
REQ-033 Clear after 2 bits: sync_clr pulse concurrent with shift_en -> bit_count=0; the next 4 bits 0,1,1,0 (dir=1) -> data_out=4'b0110.
REQ-034 Reset mid-operation: rst low for 3 ns between clock edges with fifo_count=1 and bit_count=3 -> all outputs zero immediately, before the next edge.
